// File: rtl/tx_frame_ctrl_if.sv
// Interface bundling the frame controller's MAC-side, upstream-byte, fifo-side
// and crc-monitor signals.
//   slave  : view taken by tx_frame_ctrl
//   master : view taken by the MAC/upstream/fifo/crc environment
interface tx_frame_ctrl_if;
    // MAC-side request
    logic       tx_start;
    logic [6:0] tx_len;
    // upstream payload source
    logic [7:0] data_in;
    logic       data_in_valid;
    logic       data_in_ready;
    // fifo byte input
    logic [7:0] phr_psdu_out;
    logic       phr_psdu_out_valid;
    // crc serial-output valid, watched for end of frame
    logic       tx_out_valid;
    // status
    logic       busy;
    logic       tx_done;
    logic       len_err;
    logic       underrun_err;
    logic       timeout_err;

    modport slave (
        input  tx_start,
        input  tx_len,
        input  data_in,
        input  data_in_valid,
        input  tx_out_valid,
        output data_in_ready,
        output phr_psdu_out,
        output phr_psdu_out_valid,
        output busy,
        output tx_done,
        output len_err,
        output underrun_err,
        output timeout_err
    );

    modport master (
        output tx_start,
        output tx_len,
        output data_in,
        output data_in_valid,
        output tx_out_valid,
        input  data_in_ready,
        input  phr_psdu_out,
        input  phr_psdu_out_valid,
        input  busy,
        input  tx_done,
        input  len_err,
        input  underrun_err,
        input  timeout_err
    );
endinterface

// File: rtl/tx_frame_ctrl.sv
// Transmit frame sequencer in front of the fifo -> crc chain.
// On an accepted start it emits the PHR (frame length) byte, then streams
// (len - FCS_LEN) payload bytes from upstream as one gap-free valid burst,
// then waits in DRAIN for the crc serial output to finish (a fall of
// tx_out_valid after a rise seen in DRAIN) or for a timeout.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : tx_frame_ctrl_if.slave -- start/length request, upstream byte
//              handshake, fifo byte output, crc valid monitor, status pulses
// All outputs are registered.
module tx_frame_ctrl #(
    parameter int unsigned MAX_LEN       = 127,
    parameter int unsigned FCS_LEN       = 2,
    parameter int unsigned DRAIN_TIMEOUT = 4096
) (
    input logic            clk,
    input logic            reset_n,
    tx_frame_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StPhr,
        StPsdu,
        StDrain
    } state_e;

    state_e           state_q;
    logic [6:0]       rem_q;        // payload bytes still to accept
    logic [CNT_W-1:0] drain_cnt_q;
    logic             tov_prev_q;   // tx_out_valid one cycle ago
    logic             tov_rise_q;   // a rise has been seen since entering DRAIN

    logic [7:0]       out_q;
    logic             out_valid_q;
    logic             ready_q;
    logic             busy_q;
    logic             done_q;
    logic             len_err_q;
    logic             underrun_q;
    logic             timeout_q;

    logic [31:0]      len_ext;
    logic             len_ok;
    logic             start_armed;
    logic             tov_fall;
    logic [6:0]       payload_len;

    always_comb begin
        len_ext     = 32'(bus.tx_len);
        len_ok      = (len_ext >= FCS_LEN + 1) && (len_ext <= MAX_LEN);
        // A start coinciding with the done/timeout pulse is dropped; the
        // controller re-arms one cycle later.
        start_armed = bus.tx_start && !done_q && !timeout_q;
        tov_fall    = tov_prev_q && !bus.tx_out_valid && tov_rise_q;
        payload_len = bus.tx_len - 7'(FCS_LEN);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rem_q       <= '0;
            drain_cnt_q <= '0;
            tov_prev_q  <= 1'b0;
            tov_rise_q  <= 1'b0;
            out_q       <= 8'h00;
            out_valid_q <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            len_err_q   <= 1'b0;
            underrun_q  <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            tov_prev_q <= bus.tx_out_valid;
            done_q     <= 1'b0;
            len_err_q  <= 1'b0;
            underrun_q <= 1'b0;
            timeout_q  <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b0;
                    busy_q      <= 1'b0;
                    drain_cnt_q <= '0;
                    tov_rise_q  <= 1'b0;
                    if (start_armed) begin
                        if (len_ok) begin
                            state_q     <= StPhr;
                            out_q       <= {1'b0, bus.tx_len};
                            out_valid_q <= 1'b1;
                            ready_q     <= 1'b1;
                            busy_q      <= 1'b1;
                            rem_q       <= payload_len;
                        end else begin
                            len_err_q <= 1'b1;
                        end
                    end
                end

                // PHR is on the wire this cycle in StPhr; both states accept
                // payload identically since the burst must be gap-free.
                StPhr, StPsdu: begin
                    state_q     <= StPsdu;
                    drain_cnt_q <= '0;
                    tov_rise_q  <= 1'b0;
                    if (ready_q) begin
                        if (bus.data_in_valid) begin
                            out_q       <= bus.data_in;
                            out_valid_q <= 1'b1;
                            rem_q       <= rem_q - 7'd1;
                            ready_q     <= (rem_q != 7'd1);
                        end else begin
                            out_valid_q <= 1'b0;
                            ready_q     <= 1'b0;
                            underrun_q  <= 1'b1;
                            state_q     <= StDrain;
                        end
                    end else begin
                        // last payload byte is on the wire this cycle
                        out_valid_q <= 1'b0;
                        state_q     <= StDrain;
                    end
                end

                StDrain: begin
                    out_valid_q <= 1'b0;
                    ready_q     <= 1'b0;
                    if (bus.tx_out_valid && !tov_prev_q) begin
                        tov_rise_q <= 1'b1;
                    end
                    // busy_q is left set so it covers the pulse cycle
                    if (tov_fall) begin
                        done_q  <= 1'b1;
                        state_q <= StIdle;
                    end else if (drain_cnt_q == CNT_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    always_comb begin
        bus.phr_psdu_out       = out_q;
        bus.phr_psdu_out_valid = out_valid_q;
        bus.data_in_ready      = ready_q;
        bus.busy               = busy_q;
        bus.tx_done            = done_q;
        bus.len_err            = len_err_q;
        bus.underrun_err       = underrun_q;
        bus.timeout_err        = timeout_q;
    end

endmodule

// File: tb/tb_tx_frame_ctrl.sv
// Scoreboard bench for tx_frame_ctrl. The driver works out, from the frame
// rules, which bytes/status pulses must appear and on which cycle, and
// queues them; a negedge monitor pops and compares whenever the DUT shows
// a valid byte or a status pulse, and checks busy/ready against windows.
module tb_tx_frame_ctrl;

    localparam int TO       = 16;
    localparam int EV_DONE  = 0;
    localparam int EV_LEN   = 1;
    localparam int EV_UNDER = 2;
    localparam int EV_TO    = 3;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    tx_frame_ctrl_if bus();

    tx_frame_ctrl #(
        .MAX_LEN      (127),
        .FCS_LEN      (2),
        .DRAIN_TIMEOUT(TO)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    exp_t byte_q[$];
    exp_t ev_q[$];
    exp_t mon_e;
    int   busy_from = 0, busy_to = -1;
    int   rdy_from = 0, rdy_to = -1;
    logic [7:0] pay_buf[0:127];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic take_ev(input int kind);
        exp_t e;
        if (ev_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_status: got kind %0d at cycle %0d, expected none", kind, cyc);
        end else begin
            e = ev_q.pop_front();
            chk("status_kind", kind, e.val);
            chk("status_cycle", cyc, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            if (bus.phr_psdu_out_valid) begin
                if (byte_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %02h at cycle %0d, expected none",
                             bus.phr_psdu_out, cyc);
                end else begin
                    mon_e = byte_q.pop_front();
                    chk("byte_cycle", cyc, mon_e.cyc);
                    chk("byte_value", int'(bus.phr_psdu_out), mon_e.val);
                end
            end
            if (bus.tx_done)      take_ev(EV_DONE);
            if (bus.len_err)      take_ev(EV_LEN);
            if (bus.underrun_err) take_ev(EV_UNDER);
            if (bus.timeout_err)  take_ev(EV_TO);
            chk("busy", int'(bus.busy), int'(cyc >= busy_from && cyc <= busy_to));
            chk("ready", int'(bus.data_in_ready), int'(cyc >= rdy_from && cyc <= rdy_to));
        end
    end

    task automatic drive_cycle(input int c, input int k, input int nacc, input int gap,
                               input int r_c, input int f_c, input bit hold);
        int idx;
        if (c >= k + 1 && !hold) bus.tx_start = 1'b0;
        idx = c - (k + 1);
        if (idx >= 0 && idx < nacc) begin
            bus.data_in_valid = 1'b1;
            bus.data_in       = pay_buf[idx];
        end else if (gap >= 0 && idx == nacc) begin
            bus.data_in_valid = 1'b0;
            bus.data_in       = 8'($urandom);
        end else begin
            // junk outside the accept window must be ignored
            bus.data_in_valid = 1'($urandom_range(0, 1));
            bus.data_in       = 8'($urandom);
        end
        bus.tx_out_valid = (c >= r_c && c < f_c);
    endtask

    // mode 0: tx_out_valid pulse in DRAIN -> done; 1: never -> timeout;
    // 2: high only across DRAIN entry (fall without a rise) -> timeout.
    task automatic run_frame(input int len, input int gap, input int mode, input bit hold,
                             input bit use_buf, output int e_cyc);
        int k, npay, nacc, d, r_c, f_c;
        k = cyc;
        bus.tx_start = 1'b1;
        bus.tx_len   = 7'(len);
        if (len < 3) begin
            ev_q.push_back('{cyc: k + 1, val: EV_LEN});
            drive_cycle(k, k, 0, -1, -10, -10, hold);
            @(posedge clk); #1;
            drive_cycle(cyc, k, 0, -1, -10, -10, hold);
            e_cyc = k + 1;
            return;
        end
        npay = len - 2;
        if (!use_buf) for (int i = 0; i < npay; i++) pay_buf[i] = 8'($urandom);
        nacc = (gap < 0) ? npay : gap;
        byte_q.push_back('{cyc: k + 1, val: len});
        for (int i = 0; i < nacc; i++) byte_q.push_back('{cyc: k + 2 + i, val: int'(pay_buf[i])});
        d = k + 2 + nacc;
        if (gap >= 0) ev_q.push_back('{cyc: d, val: EV_UNDER});
        if (mode == 0) begin
            r_c   = d + $urandom_range(0, 3);
            f_c   = r_c + $urandom_range(1, 6);
            e_cyc = f_c + 1;
            ev_q.push_back('{cyc: e_cyc, val: EV_DONE});
        end else begin
            r_c   = (mode == 2) ? d - 1 : -10;
            f_c   = (mode == 2) ? d + 1 : -10;
            e_cyc = d + TO;
            ev_q.push_back('{cyc: e_cyc, val: EV_TO});
        end
        busy_from = k + 1;
        busy_to   = e_cyc;
        rdy_from  = k + 1;
        rdy_to    = (gap < 0) ? k + npay : k + 1 + gap;
        drive_cycle(k, k, nacc, gap, r_c, f_c, hold);
        do begin
            @(posedge clk); #1;
            drive_cycle(cyc, k, nacc, gap, r_c, f_c, hold);
        end while (cyc < e_cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            bus.tx_start      = 1'b0;
            bus.data_in_valid = 1'($urandom_range(0, 1));
            bus.data_in       = 8'($urandom);
            bus.tx_out_valid  = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_out"}, int'(bus.phr_psdu_out), 0);
        chk({tag, "_valid"}, int'(bus.phr_psdu_out_valid), 0);
        chk({tag, "_ready"}, int'(bus.data_in_ready), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.tx_done), 0);
        chk({tag, "_len_err"}, int'(bus.len_err), 0);
        chk({tag, "_underrun"}, int'(bus.underrun_err), 0);
        chk({tag, "_timeout"}, int'(bus.timeout_err), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int e, k, len, gap, mode, m;
        logic [7:0] fixed [0:7];
        fixed = '{8'h07, 8'h03, 8'h01, 8'h05, 8'h21, 8'h43, 8'h65, 8'h87};
        bus.tx_start      = 1'b0;
        bus.tx_len        = '0;
        bus.data_in       = '0;
        bus.data_in_valid = 1'b0;
        bus.tx_out_valid  = 1'b0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        mon_en  = 1'b1;
        idle(2);

        // reference frame with fixed payload
        for (int i = 0; i < 8; i++) pay_buf[i] = fixed[i];
        run_frame(10, -1, 0, 1'b0, 1'b1, e);
        idle(2);

        // length boundaries
        run_frame(2, -1, 0, 1'b0, 1'b0, e);
        idle(1);
        run_frame(0, -1, 0, 1'b0, 1'b0, e);
        idle(1);
        run_frame(3, -1, 0, 1'b0, 1'b0, e);
        idle(1);
        run_frame(127, -1, 0, 1'b0, 1'b0, e);
        idle(1);

        // underrun after two payload bytes
        run_frame(6, 2, 0, 1'b0, 1'b0, e);
        idle(1);
        // drain timeout, and a fall with no rise inside DRAIN
        run_frame(5, -1, 1, 1'b0, 1'b0, e);
        idle(1);
        run_frame(4, -1, 2, 1'b0, 1'b0, e);
        idle(2);

        // asynchronous reset in the middle of the payload
        k = cyc;
        bus.tx_start = 1'b1;
        bus.tx_len   = 7'd20;
        for (int i = 0; i < 4; i++) pay_buf[i] = 8'($urandom);
        byte_q.push_back('{cyc: k + 1, val: 20});
        byte_q.push_back('{cyc: k + 2, val: int'(pay_buf[0])});
        byte_q.push_back('{cyc: k + 3, val: int'(pay_buf[1])});
        busy_from = k + 1;
        busy_to   = k + 3;
        rdy_from  = k + 1;
        rdy_to    = k + 3;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            bus.tx_start      = 1'b0;
            bus.data_in_valid = 1'b1;
            bus.data_in       = pay_buf[i];
        end
        #3 reset_n = 1'b0;
        #1 chk_all_zero("midreset");
        bus.data_in_valid = 1'b0;
        #19 reset_n = 1'b1;
        idle(2);
        run_frame(7, -1, 0, 1'b0, 1'b0, e);
        idle(1);

        // tx_start held through a whole frame
        run_frame(8, -1, 0, 1'b1, 1'b0, e);
        @(posedge clk); #1;
        run_frame(9, -1, 0, 1'b0, 1'b0, e);
        idle(1);

        // randomized frames
        for (int n = 0; n < 40; n++) begin
            m = $urandom_range(0, 15);
            if (m == 0)      len = $urandom_range(0, 2);
            else if (m == 1) len = 127;
            else             len = $urandom_range(3, 40);
            gap = -1;
            if (len >= 3 && $urandom_range(0, 3) == 0) gap = $urandom_range(0, len - 3);
            m = $urandom_range(0, 7);
            mode = (m == 0) ? 1 : (m == 1) ? 2 : 0;
            run_frame(len, gap, mode, 1'b0, 1'b0, e);
            idle($urandom_range(1, 3));
        end

        idle(4);
        chk("bytes_left", byte_q.size(), 0);
        chk("status_left", ev_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/tx_frame_ctrl.md
Name: tx_frame_ctrl

Overview:
Frame-level sequencer in front of the fifo -> crc transmit chain. On a start request it emits the PHR byte (frame length) and then pulls exactly (length - FCS_LEN) PSDU payload bytes from an upstream byte source. It drives these as one contiguous valid burst into the fifo's byte input. It then watches the crc serial output to detect end of frame, and reports done, busy and error status to the MAC-side controller.

Parameters:
MAX_LEN, 127, largest legal frame length in bytes (PHR value), FCS included
FCS_LEN, 2, FCS bytes appended by crc; counted in length, never supplied by upstream
DRAIN_TIMEOUT, 4096, max cycles in DRAIN before timeout error; counter width = clog2(DRAIN_TIMEOUT+1)

Ports:
clk  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
tx_start  in  1  one-cycle frame start request, sampled only in IDLE
tx_len  in  7  frame length (PSDU incl. FCS), sampled with tx_start
data_in  in  8  upstream payload byte
data_in_valid  in  1  upstream byte valid
data_in_ready  out  1  controller accepts data_in this cycle
phr_psdu_out  out  8  byte to fifo_input
phr_psdu_out_valid  out  1  to fifo_input_valid
tx_out_valid  in  1  crc serial-output valid, monitored for end of frame
busy  out  1  frame in progress (any state other than IDLE)
tx_done  out  1  one-cycle pulse, frame fully serialized
len_err  out  1  one-cycle pulse, tx_start rejected
underrun_err  out  1  one-cycle pulse, payload gap aborted frame
timeout_err  out  1  one-cycle pulse, DRAIN timed out

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; phr_psdu_out=8'h00; counters 0. Reset mid-frame aborts immediately with no status pulse. phr_psdu_out_valid drops at once.
- All outputs are registered. States: IDLE, PHR, PSDU, DRAIN.
- IDLE:
  - tx_start=1 with FCS_LEN+1 <= tx_len <= MAX_LEN: latch len; payload count = len - FCS_LEN; next state PHR.
  - tx_start=1 with tx_len out of range (0..2 at defaults): len_err pulses next cycle; stay IDLE.
- PHR (1 cycle): phr_psdu_out={1'b0,len}, valid=1, data_in_ready=1; next state PSDU. The first valid byte appears the cycle after tx_start, so start->PHR latency is 1.
- PSDU:
  - data_in_ready=1 while the remaining count > 0.
  - Each cycle with data_in_valid & data_in_ready, data_in is registered to phr_psdu_out with valid=1 on the next cycle, and the count decrements. Output latency is 1, throughput 1 byte/cycle.
  - The burst from PHR to the last payload byte is gap-free. The upstream must present valid back-to-back starting in the PHR cycle.
  - data_in_valid=0 while ready=1: valid=0 that cycle, underrun_err pulses, state goes to DRAIN. The fifo/crc flush the partial frame.
  - When the final byte is accepted, ready drops the same cycle. The last out-valid follows next cycle, then state DRAIN.
- DRAIN:
  - valid=0, ready=0.
  - Waits for tx_out_valid 1->0, via a registered previous value. Only a fall seen after entering DRAIN counts; a fall with no prior rise in DRAIN is ignored.
  - On the fall: tx_done pulses, state IDLE.
  - A cycle counter runs from entry. On reaching DRAIN_TIMEOUT: timeout_err pulses, state IDLE, no tx_done.
- tx_start outside IDLE is ignored, with no error. A tx_start in the same cycle that tx_done/timeout_err is asserted is also ignored; the controller re-arms the cycle after.
- busy=1 from the cycle after an accepted tx_start through the cycle in which tx_done or an error pulses.
- Upstream data is ignored outside PSDU/PHR, because ready is low there.
- Length wrap: the payload counter is 7 bits and never underflows. The minimum payload is 1 byte.

Test Plan:
- tx_len=10, upstream streams 07,03,01,05,21,43,65,87 back-to-back -> out bytes 0A,07,03,01,05,21,43,65,87 on 9 consecutive cycles. After tx_out_valid rise/fall, tx_done pulses once and busy returns to 0.
- tx_len=2, then tx_len=0, then tx_len=... (7-bit max 127 is legal; drive 3 and 127) -> len_err for 2 and 0, busy stays 0. tx_len=3 gives PHR 03 plus 1 payload byte. tx_len=127 gives 125 payload bytes and valid high for 126 cycles.
- tx_len=6, data_in_valid dropped after 2 payload bytes -> underrun_err pulse, valid low from the gap cycle, DRAIN entered, no tx_done until tx_out_valid falls.
- tx_out_valid held 0 in DRAIN -> timeout_err exactly DRAIN_TIMEOUT cycles after DRAIN entry, then IDLE. Repeat with DRAIN_TIMEOUT=16.
- reset_n pulsed low for 20 ns mid-PSDU (mirrors existing async reset timing) -> all outputs 0 immediately, no status pulse. A new tx_start after release is accepted normally.
- tx_start held high through a whole frame -> second frame starts only after IDLE is re-entered; no len_err; the mid-frame start is ignored.
